// File: rtl/line_scan_feeder_pkg.sv
// Shared types for the collision pipeline: endpoint/segment structs, line ID width
// and the feeder state encoding.
package line_scan_feeder_pkg;

  localparam int unsigned LINE_ID_W = 8;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } Point;

  typedef struct packed {
    Point s;
    Point e;
  } Line;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/line_scan_feeder_line_store.sv
// Obstacle table: DEPTH x 48-bit register file, one write port, one async read port.
module line_store
  import line_scan_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  Line           wdata,
  input  logic [AW-1:0] raddr,
  output Line           rdata
);

  Line mem [DEPTH];

  // Contents are never reset; validity is tracked by the feeder's count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/line_scan_feeder.sv
// Streams one (query, obstacle, lineID) beat per cycle over the stored obstacle table
// for each accepted query, ending each scan with a one-cycle scan_done pulse.
module line_scan_feeder
  import line_scan_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_val,
  output logic                 ld_rdy,
  input  logic [7:0]           ld_x1,
  input  logic [7:0]           ld_y1,
  input  logic [7:0]           ld_z1,
  input  logic [7:0]           ld_x2,
  input  logic [7:0]           ld_y2,
  input  logic [7:0]           ld_z2,
  input  logic                 clr,
  input  logic                 q_val,
  output logic                 q_rdy,
  input  logic [7:0]           q_x1,
  input  logic [7:0]           q_y1,
  input  logic [7:0]           q_z1,
  input  logic [7:0]           q_x2,
  input  logic [7:0]           q_y2,
  input  logic [7:0]           q_z2,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [7:0]           out_ax1,
  output logic [7:0]           out_ay1,
  output logic [7:0]           out_az1,
  output logic [7:0]           out_ax2,
  output logic [7:0]           out_ay2,
  output logic [7:0]           out_az2,
  output logic [7:0]           out_bx1,
  output logic [7:0]           out_by1,
  output logic [7:0]           out_bz1,
  output logic [7:0]           out_bx2,
  output logic [7:0]           out_by2,
  output logic [7:0]           out_bz2,
  output logic [LINE_ID_W-1:0] lineID,
  output logic                 out_last,
  output logic                 scan_done,
  output logic [CW-1:0]        count,
  output logic                 full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t               state;
  logic [LINE_ID_W-1:0] idx;
  logic [LINE_ID_W-1:0] line_id_q;
  logic [LINE_ID_W-1:0] last_idx;
  Line                  q_lat;
  Line                  b_reg;
  Line                  ld_line;
  Line                  q_line;
  Line                  rd_line;
  logic                 ld_fire;
  logic                 q_fire;
  logic                 empty_after;

  assign ld_line = '{s: '{x: ld_x1, y: ld_y1, z: ld_z1}, e: '{x: ld_x2, y: ld_y2, z: ld_z2}};
  assign q_line  = '{s: '{x: q_x1,  y: q_y1,  z: q_z1},  e: '{x: q_x2,  y: q_y2,  z: q_z2}};

  assign ld_rdy   = (state == IDLE) && (count < DEPTH_C);
  assign q_rdy    = (state == IDLE);
  assign full     = (count == DEPTH_C);
  assign ld_fire  = ld_val && ld_rdy && !clr;
  assign q_fire   = q_val && q_rdy;
  assign last_idx = LINE_ID_W'(count) - LINE_ID_W'(1);
  // Count as seen after this edge: clr wins, otherwise a same-cycle load is included.
  assign empty_after = clr || ((count == '0) && !ld_fire);

  line_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (count[AW-1:0]),
    .wdata (ld_line),
    .raddr (idx[AW-1:0]),
    .rdata (rd_line)
  );

  // idx is the fetch pointer: it runs one entry ahead of the registered beat, so the
  // output stage refills from the table on the same edge that consumes a beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      line_id_q <= '0;
      q_lat     <= '0;
      b_reg     <= '0;
      out_val   <= 1'b0;
      out_last  <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;

      if (clr)          count <= '0;
      else if (ld_fire) count <= count + CW'(1);

      case (state)
        IDLE: begin
          if (q_fire) begin
            q_lat <= q_line;
            idx   <= '0;
            if (empty_after) scan_done <= 1'b1;
            else             state     <= SCAN;
          end
        end
        SCAN: begin
          if (clr) begin
            state    <= IDLE;
            out_val  <= 1'b0;
            out_last <= 1'b0;
          end else if (out_val && out_rdy && out_last) begin
            state     <= IDLE;
            out_val   <= 1'b0;
            out_last  <= 1'b0;
            scan_done <= 1'b1;
          end else if (!out_val || out_rdy) begin
            out_val   <= 1'b1;
            line_id_q <= idx;
            b_reg     <= rd_line;
            out_last  <= (idx == last_idx);
            idx       <= idx + LINE_ID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lineID  = line_id_q;
  assign out_ax1 = q_lat.s.x;
  assign out_ay1 = q_lat.s.y;
  assign out_az1 = q_lat.s.z;
  assign out_ax2 = q_lat.e.x;
  assign out_ay2 = q_lat.e.y;
  assign out_az2 = q_lat.e.z;
  assign out_bx1 = b_reg.s.x;
  assign out_by1 = b_reg.s.y;
  assign out_bz1 = b_reg.s.z;
  assign out_bx2 = b_reg.e.x;
  assign out_by2 = b_reg.e.y;
  assign out_bz2 = b_reg.e.z;

endmodule

// File: tb/tb_line_scan_feeder.sv
// Directed bench for line_scan_feeder: load, scan, stall, full, empty, clr abort and
// asynchronous reset cases against a small table model.
module tb_line_scan_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_val = 1'b0;
  logic          clr = 1'b0;
  logic          q_val = 1'b0;
  logic          out_rdy = 1'b0;
  logic [47:0]   ld_seg = '0;
  logic [47:0]   q_seg = '0;
  logic          ld_rdy, q_rdy, out_val, out_last, scan_done, full;
  logic [7:0]    out_ax1, out_ay1, out_az1, out_ax2, out_ay2, out_az2;
  logic [7:0]    out_bx1, out_by1, out_bz1, out_bx2, out_by2, out_bz2;
  logic [7:0]    lineID;
  logic [CW-1:0] count;
  logic [47:0]   oa, ob;

  logic [47:0] tab [DEPTH];
  int          n = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign oa = {out_ax1, out_ay1, out_az1, out_ax2, out_ay2, out_az2};
  assign ob = {out_bx1, out_by1, out_bz1, out_bx2, out_by2, out_bz2};

  line_scan_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ld_val(ld_val), .ld_rdy(ld_rdy),
    .ld_x1(ld_seg[47:40]), .ld_y1(ld_seg[39:32]), .ld_z1(ld_seg[31:24]),
    .ld_x2(ld_seg[23:16]), .ld_y2(ld_seg[15:8]),  .ld_z2(ld_seg[7:0]),
    .clr(clr), .q_val(q_val), .q_rdy(q_rdy),
    .q_x1(q_seg[47:40]), .q_y1(q_seg[39:32]), .q_z1(q_seg[31:24]),
    .q_x2(q_seg[23:16]), .q_y2(q_seg[15:8]),  .q_z2(q_seg[7:0]),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_ax1(out_ax1), .out_ay1(out_ay1), .out_az1(out_az1),
    .out_ax2(out_ax2), .out_ay2(out_ay2), .out_az2(out_az2),
    .out_bx1(out_bx1), .out_by1(out_by1), .out_bz1(out_bz1),
    .out_bx2(out_bx2), .out_by2(out_by2), .out_bz2(out_bz2),
    .lineID(lineID), .out_last(out_last), .scan_done(scan_done),
    .count(count), .full(full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [47:0] mk(input logic [7:0] b);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4, b + 8'd5};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [47:0] d);
    ld_seg = d;
    ld_val = 1'b1;
    tick;
    ld_val = 1'b0;
    if (n < DEPTH) begin
      tab[n] = d;
      n++;
    end
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n = 0;
  endtask

  // Starts in the cycle right after the query was accepted, with out_rdy held high.
  task automatic expect_beats(input string tag, input logic [47:0] q);
    check({tag, "_lat_val"}, 64'(out_val), 64'(0));
    check({tag, "_lat_qrdy"}, 64'(q_rdy), 64'(0));
    for (int i = 0; i < n; i++) begin
      tick;
      check($sformatf("%s_val%0d", tag, i), 64'(out_val), 64'(1));
      check($sformatf("%s_id%0d", tag, i), 64'(lineID), 64'(i));
      check($sformatf("%s_b%0d", tag, i), 64'(ob), 64'(tab[i]));
      check($sformatf("%s_a%0d", tag, i), 64'(oa), 64'(q));
      check($sformatf("%s_last%0d", tag, i), 64'(out_last), 64'(i == n - 1));
      check($sformatf("%s_done%0d", tag, i), 64'(scan_done), 64'(0));
    end
    tick;
    check({tag, "_done"}, 64'(scan_done), 64'(1));
    check({tag, "_endval"}, 64'(out_val), 64'(0));
    check({tag, "_endqrdy"}, 64'(q_rdy), 64'(1));
    tick;
    check({tag, "_donepulse"}, 64'(scan_done), 64'(0));
  endtask

  task automatic run_scan(input string tag, input logic [47:0] q);
    out_rdy = 1'b1;
    q_seg = q;
    q_val = 1'b1;
    tick;
    q_val = 1'b0;
    expect_beats(tag, q);
  endtask

  initial begin
    int          ids [5];
    logic        rdys [5];
    ids  = '{0, 1, 1, 1, 2};
    rdys = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    check("rst_val", 64'(out_val), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_done", 64'(scan_done), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_id", 64'(lineID), 64'(0));
    check("rst_a", 64'(oa), 64'(0));
    check("rst_b", 64'(ob), 64'(0));
    check("rst_ldrdy", 64'(ld_rdy), 64'(1));
    check("rst_qrdy", 64'(q_rdy), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    tick;

    // Three lines, free-flowing scan
    load(mk(8'h10));
    load(mk(8'h20));
    load(mk(8'h30));
    check("ld3_count", 64'(count), 64'(3));
    check("ld3_full", 64'(full), 64'(0));
    run_scan("s3", mk(8'hA0));
    check("s3_count", 64'(count), 64'(3));

    // Stall on beat 1 for two cycles
    q_seg = mk(8'hB0);
    q_val = 1'b1;
    out_rdy = 1'b1;
    tick;
    q_val = 1'b0;
    check("st_lat_val", 64'(out_val), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick;
      out_rdy = rdys[i];
      check($sformatf("st_val%0d", i), 64'(out_val), 64'(1));
      check($sformatf("st_id%0d", i), 64'(lineID), 64'(ids[i]));
      check($sformatf("st_b%0d", i), 64'(ob), 64'(tab[ids[i]]));
      check($sformatf("st_last%0d", i), 64'(out_last), 64'(ids[i] == 2));
    end
    tick;
    check("st_done", 64'(scan_done), 64'(1));
    check("st_endval", 64'(out_val), 64'(0));

    // Fill the table, then one extra load that must be dropped
    do_clr;
    check("clr_count", 64'(count), 64'(0));
    for (int i = 0; i < DEPTH; i++) load(mk(8'(64 + 7 * i)));
    check("full_full", 64'(full), 64'(1));
    check("full_ldrdy", 64'(ld_rdy), 64'(0));
    check("full_count", 64'(count), 64'(DEPTH));
    load(mk(8'hEE));
    check("full_extra_count", 64'(count), 64'(DEPTH));
    run_scan("sf", mk(8'hC0));

    // Empty query
    do_clr;
    q_seg = mk(8'hD0);
    q_val = 1'b1;
    tick;
    q_val = 1'b0;
    check("emp_done", 64'(scan_done), 64'(1));
    check("emp_val", 64'(out_val), 64'(0));
    check("emp_qrdy", 64'(q_rdy), 64'(1));
    tick;
    check("emp_done_low", 64'(scan_done), 64'(0));
    check("emp_val2", 64'(out_val), 64'(0));

    // clr + load + query together: load discarded, empty scan
    load(mk(8'h50));
    load(mk(8'h58));
    ld_seg = mk(8'h60);
    ld_val = 1'b1;
    clr = 1'b1;
    q_val = 1'b1;
    tick;
    ld_val = 1'b0;
    clr = 1'b0;
    q_val = 1'b0;
    n = 0;
    check("cq_done", 64'(scan_done), 64'(1));
    check("cq_count", 64'(count), 64'(0));
    check("cq_val", 64'(out_val), 64'(0));
    tick;
    check("cq_done_low", 64'(scan_done), 64'(0));
    check("cq_val2", 64'(out_val), 64'(0));

    // Load and query in the same cycle on an empty table: new entry is scanned
    ld_seg = mk(8'h70);
    ld_val = 1'b1;
    q_seg = mk(8'hE0);
    q_val = 1'b1;
    tick;
    ld_val = 1'b0;
    q_val = 1'b0;
    tab[0] = mk(8'h70);
    n = 1;
    expect_beats("lq", mk(8'hE0));

    // clr on the second beat of a four-line scan
    do_clr;
    for (int i = 0; i < 4; i++) load(mk(8'(128 + 9 * i)));
    q_seg = mk(8'hF0);
    q_val = 1'b1;
    out_rdy = 1'b1;
    tick;
    q_val = 1'b0;
    tick;
    check("ab_id0", 64'(lineID), 64'(0));
    tick;
    check("ab_id1", 64'(lineID), 64'(1));
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n = 0;
    check("ab_val", 64'(out_val), 64'(0));
    check("ab_done", 64'(scan_done), 64'(0));
    check("ab_count", 64'(count), 64'(0));
    check("ab_qrdy", 64'(q_rdy), 64'(1));
    tick;
    check("ab_done2", 64'(scan_done), 64'(0));
    check("ab_val2", 64'(out_val), 64'(0));

    // Asynchronous reset in the middle of a scan
    load(mk(8'h11));
    load(mk(8'h22));
    q_seg = mk(8'h33);
    q_val = 1'b1;
    tick;
    q_val = 1'b0;
    tick;
    check("ar_pre_val", 64'(out_val), 64'(1));
    #2 reset = 1'b0;
    #1;
    n = 0;
    check("ar_val", 64'(out_val), 64'(0));
    check("ar_count", 64'(count), 64'(0));
    check("ar_id", 64'(lineID), 64'(0));
    check("ar_qrdy", 64'(q_rdy), 64'(1));
    @(posedge clk);
    #3 reset = 1'b1;
    tick;
    check("ar_post_done", 64'(scan_done), 64'(0));
    check("ar_post_val", 64'(out_val), 64'(0));
    load(mk(8'h44));
    run_scan("ar", mk(8'h55));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/line_scan_feeder.md
# line_scan_feeder

Upstream feeder for the collision detection stage. Holds a table of up to DEPTH obstacle line segments with 8-bit x/y/z endpoints. For each accepted query segment it streams one (query, obstacle, lineID) beat per cycle to the downstream orientation/intersection pipeline under valid/ready flow control. It signals the end of each scan with a one-cycle done pulse.

## Interface
Parameters:
- DEPTH, 16: obstacle table entries; legal range 1..255, because the ID is 8 bits.
- CW, $clog2(DEPTH+1): width of the count output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ld_val  in  1  obstacle write request
- ld_rdy  out  1  obstacle write accepted; equals (state==IDLE && count<DEPTH)
- ld_x1, ld_y1, ld_z1, ld_x2, ld_y2, ld_z2  in  8 each  obstacle endpoints (unsigned)
- clr  in  1  synchronous table clear
- q_val  in  1  query request
- q_rdy  out  1  query accepted; equals (state==IDLE)
- q_x1, q_y1, q_z1, q_x2, q_y2, q_z2  in  8 each  query endpoints
- out_val  out  1  beat valid
- out_rdy  in  1  downstream ready
- out_ax1..out_az2  out  8 each  latched query endpoints
- out_bx1..out_bz2  out  8 each  obstacle endpoints for this beat
- lineID  out  8  table index of the obstacle
- out_last  out  1  final beat of the scan
- scan_done  out  1  one-cycle pulse, scan complete
- count  out  CW  entries stored
- full  out  1  count==DEPTH

## Operation
- States:
  - IDLE: the only state that accepts loads and queries.
  - SCAN: streaming beats.
- Load: on ld_val && ld_rdy, the segment is written at index count, and count increments. ld_val is ignored when ld_rdy is low; the entry is dropped with no error flag.
- Query: on q_val && q_rdy, the six query coordinates are latched.
  - If the post-edge count > 0: go to SCAN with idx=0.
  - If the post-edge count == 0: stay in IDLE and pulse scan_done on the next cycle, with no beats.
- SCAN:
  - out_val=1, lineID=idx, out_b* = table[idx], out_last = (idx==count-1).
  - On out_val && out_rdy: idx increments.
  - On the last handshake: go to IDLE and pulse scan_done.
  - Outputs hold stable while out_rdy=0.
- clr:
  - Sets count=0; table contents are not erased.
  - In SCAN, clr aborts the scan: next cycle out_val=0, state=IDLE, and there is no scan_done.
  - clr has priority over a same-cycle load; the load is discarded.
  - clr with a same-cycle query in IDLE: the query is accepted and completes as an empty scan.
- Load and query in the same IDLE cycle: both are accepted, and the new entry is included in the scan.
- All outputs are registered. ld_rdy, q_rdy and full are decoded from registered state and count.

## Timing
- Reset assertion (reset=0) is asynchronous. The following take effect immediately and hold until the first edge after deassertion:
  - state=IDLE, count=0, idx=0.
  - out_val=0, out_last=0, scan_done=0.
  - All out_a*/out_b*/lineID=0.
  - ld_rdy=1, q_rdy=1, full=0.
- Reset in mid-scan: the scan is lost, no scan_done is issued, and the table is effectively empty.
- Query accepted at edge k: out_val=1 with lineID=0 after edge k+1, so first-beat latency is one cycle.
- With out_rdy held high, N stored lines produce N consecutive beats.
  - scan_done is high for the cycle after the edge that accepted the last beat.
  - q_rdy is high in that same cycle.
- Back-to-back queries: the next query can be accepted in the scan_done cycle.
- Empty query accepted at edge k: scan_done is high in the cycle after edge k; out_val stays 0.

## Structure
- Shared package (used by the collision pipeline):
  - typedefs Point {x,y,z: 8 bits} and Line {s,e: Point}.
  - constant LINE_ID_W=8.
  - state enum {IDLE, SCAN}.
- Sub-module line_store: DEPTH x 48-bit register file with one write port and one asynchronous read port indexed by idx.
- The FSM, counters and output registers live in line_scan_feeder.

## Test plan
- Reset, then load 3 lines (IDs 0..2), then a query with out_rdy=1 -> beats on 3 consecutive cycles with lineID 0,1,2 and out_last only on lineID 2; scan_done the cycle after; count=3.
- out_rdy toggled 1,0,0,1 during a 3-line scan -> lineID holds at 1 for the stalled cycles, no beat is lost or duplicated, and out_b* match the stored values.
- Load DEPTH lines, then drive one more ld_val -> full=1, ld_rdy=0, count=DEPTH; the extra segment is absent from the subsequent scan.
- Query with count=0 -> no out_val, scan_done pulses one cycle after acceptance; clr and query in the same cycle behave identically.
- clr asserted on the 2nd beat of a 4-line scan -> out_val low on the next cycle, no scan_done, count=0, q_rdy=1.
- reset driven low asynchronously mid-scan, between clock edges -> out_val=0 and count=0 immediately; after release a 1-line load and query yield lineID 0.
